i2c_target: RTL and testbench

// - 7-bit-address I2C target (responder): the bus-side counterpart of the i2c master FSM.
// - Oversamples SCL/SDA with the system clock, detects START/STOP, matches its address,

---
 rtl/i2c_target_pkg.sv | 23 ++
 rtl/i2c_target_if.sv | 23 ++
 rtl/i2c_line_sync.sv | 41 ++++
 rtl/i2c_target.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_target.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_target_pkg.sv
// rtl/i2c_target_pkg.sv - shared state encodings and address-match helper for the I2C target
package i2c_target_pkg;

   // 7-bit general call address; never acknowledged by this target
   localparam logic [6:0] k_general_call = 7'h00;

   typedef enum logic [3:0] {
      k_t_idle     = 4'd0,
      k_t_addr     = 4'd1,
      k_t_addr_ack = 4'd2,
      k_t_wr_data  = 4'd3,
      k_t_wr_ack   = 4'd4,
      k_t_rd_data  = 4'd5,
      k_t_rd_ack   = 4'd6,
      k_t_ignore   = 4'd7
   } t_state_e;

   // True when a received 7-bit address selects this target (general call excluded)
   function automatic logic addr_match(input logic [6:0] rx_addr, input logic [6:0] own_addr);
      return (rx_addr == own_addr) && (rx_addr != k_general_call);
   endfunction

endpackage

// File: rtl/i2c_target_if.sv
// rtl/i2c_target_if.sv - bus pins and fabric handshake of the I2C target
interface i2c_target_if;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_req;
   logic [7:0] tx_data;
   logic       busy;

   // target side: samples pins and read data, drives SDA enable and fabric strobes
   modport slave (
      input  scl_in, sda_in, tx_data,
      output sda_oe, rx_data, rx_valid, tx_req, busy
   );

   // bus/fabric side as seen by whoever models the master and the read-data source
   modport master (
      output scl_in, sda_in, tx_data,
      input  sda_oe, rx_data, rx_valid, tx_req, busy
   );
endinterface

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - multi-flop synchroniser plus edge detect for one bus line
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic line_in,
   output logic level,
   output logic rise,
   output logic fall
);

   if (SYNC_STAGES < 2) begin : g_stages_chk
      $error("i2c_line_sync: SYNC_STAGES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   // shift the raw pin into the chain and remember the previous synced level
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], line_in};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   // idle bus reads high, so reset to 1 to avoid a spurious edge after reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - 7-bit address I2C target: address match, write bytes out, read bytes in
module i2c_target
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] ADDR        = 7'h42,
   parameter int         SYNC_STAGES = 2
) (
   input logic        clk,
   input logic        reset,
   i2c_target_if.slave bus
);

   if (ADDR == k_general_call) begin : g_addr_chk
      $error("i2c_target: ADDR 0x00 is the general call address and can never match");
   end

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start_det, stop_det;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
      .clk     (clk),
      .reset   (reset),
      .line_in (bus.scl_in),
      .level   (scl_lvl),
      .rise    (scl_rise),
      .fall    (scl_fall)
   );

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
      .clk     (clk),
      .reset   (reset),
      .line_in (bus.sda_in),
      .level   (sda_lvl),
      .rise    (sda_rise),
      .fall    (sda_fall)
   );

   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;

   t_state_e   state_q, state_d;
   logic [2:0] bit_ctr_q, bit_ctr_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] tx_byte_q, tx_byte_d;
   logic       cap_q, cap_d;
   logic       rd_load_q, rd_load_d;
   logic       sda_oe_q, sda_oe_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_req_q, tx_req_d;
   logic       busy_q, busy_d;

   // next-state and output decode; START/STOP override any coincident SCL edge
   always_comb begin
      state_d    = state_q;
      bit_ctr_d  = bit_ctr_q;
      shift_d    = shift_q;
      rd_load_d  = rd_load_q;
      sda_oe_d   = sda_oe_q;
      rx_data_d  = rx_data_q;
      busy_d     = busy_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      // fabric answers tx_req on the following cycle; grab tx_data one cycle after the pulse
      cap_d      = tx_req_q;
      tx_byte_d  = cap_q ? bus.tx_data : tx_byte_q;

      if (start_det) begin
         state_d   = k_t_addr;
         bit_ctr_d = 3'd0;
         shift_d   = 8'h00;
         sda_oe_d  = 1'b0;
         rd_load_d = 1'b0;
         busy_d    = 1'b1;
      end else if (stop_det) begin
         state_d   = k_t_idle;
         bit_ctr_d = 3'd0;
         sda_oe_d  = 1'b0;
         rd_load_d = 1'b0;
         busy_d    = 1'b0;
      end else begin
         case (state_q)
            k_t_addr: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda_lvl};
                  bit_ctr_d = bit_ctr_q + 3'd1;
                  if (bit_ctr_q == 3'd7) begin
                     if (addr_match(shift_d[7:1], ADDR)) begin
                        state_d  = k_t_addr_ack;
                        tx_req_d = shift_d[0];
                     end else begin
                        state_d  = k_t_ignore;
                     end
                  end
               end
            end
            k_t_addr_ack: begin
               // first fall pulls SDA for the ACK clock, second fall ends it
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else if (shift_q[0]) begin
                     state_d  = k_t_rd_data;
                     shift_d  = tx_byte_q;
                     sda_oe_d = ~tx_byte_q[7];
                  end else begin
                     state_d  = k_t_wr_data;
                     sda_oe_d = 1'b0;
                  end
               end
            end
            k_t_wr_data: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda_lvl};
                  bit_ctr_d = bit_ctr_q + 3'd1;
                  if (bit_ctr_q == 3'd7) begin
                     rx_data_d  = shift_d;
                     rx_valid_d = 1'b1;
                     state_d    = k_t_wr_ack;
                  end
               end
            end
            k_t_wr_ack: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = k_t_wr_data;
                  end
               end
            end
            k_t_rd_data: begin
               // after an ACKed byte the first fall loads the freshly fetched byte
               if (scl_fall) begin
                  if (rd_load_q) begin
                     rd_load_d = 1'b0;
                     shift_d   = tx_byte_q;
                     sda_oe_d  = ~tx_byte_q[7];
                  end else if (bit_ctr_q == 3'd7) begin
                     bit_ctr_d = 3'd0;
                     sda_oe_d  = 1'b0;
                     state_d   = k_t_rd_ack;
                  end else begin
                     bit_ctr_d = bit_ctr_q + 3'd1;
                     shift_d   = {shift_q[6:0], 1'b0};
                     sda_oe_d  = ~shift_q[6];
                  end
               end
            end
            k_t_rd_ack: begin
               if (scl_rise) begin
                  if (!sda_lvl) begin
                     tx_req_d  = 1'b1;
                     rd_load_d = 1'b1;
                     state_d   = k_t_rd_data;
                  end else begin
                     state_d   = k_t_ignore;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // state and registered outputs; reset releases SDA immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= k_t_idle;
         bit_ctr_q  <= 3'd0;
         shift_q    <= 8'h00;
         tx_byte_q  <= 8'h00;
         cap_q      <= 1'b0;
         rd_load_q  <= 1'b0;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_ctr_q  <= bit_ctr_d;
         shift_q    <= shift_d;
         tx_byte_q  <= tx_byte_d;
         cap_q      <= cap_d;
         rd_load_q  <= rd_load_d;
         sda_oe_q   <= sda_oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q   <= tx_req_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.sda_oe   = sda_oe_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.tx_req   = tx_req_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - open-drain bus model and directed plus random checks of i2c_target
module tb_i2c_target;
   import i2c_target_pkg::*;

   localparam logic [6:0] own_addr    = 7'h42;
   localparam int         sync_stages = 2;
   localparam int         q           = 600;   // quarter SCL period; clk period is 20

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;

   i2c_target_if bus ();

   assign bus.scl_in = scl_m;
   assign bus.sda_in = sda_m & ~bus.sda_oe;

   i2c_target #(.ADDR(own_addr), .SYNC_STAGES(sync_stages)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int rx_cnt = 0;
   int tx_cnt = 0;
   int oe_cnt = 0;
   int both_cnt = 0;
   logic [7:0] rx_last = 8'h00;
   logic [7:0] tx_mem [0:31];
   int tx_wr = 0;
   int tx_rd = 0;

   // fabric model and strobe monitor, sampled on the falling clk edge
   always @(negedge clk) begin
      if (bus.rx_valid) begin
         rx_cnt++;
         rx_last = bus.rx_data;
      end
      if (bus.tx_req) begin
         tx_cnt++;
         bus.tx_data = tx_mem[tx_rd % 32];
         tx_rd++;
      end
      if (bus.rx_valid && bus.tx_req) both_cnt++;
      if (bus.sda_oe) oe_cnt++;
   end

   initial begin
      #2000000;
      $error("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_tx(input logic [7:0] b);
      tx_mem[tx_wr % 32] = b;
      tx_wr++;
   endtask

   // reference rule: only the own, non-general-call address is acknowledged
   function automatic logic model_hit(input logic [6:0] a);
      return (a == own_addr) && (a != 7'h00);
   endfunction

   // bus tasks start and end a quarter period after an SCL fall (SCL low)
   task automatic i2c_start();
      sda_m = 1'b0; #q;
      scl_m = 1'b0; #q;
   endtask

   task automatic i2c_rstart();
      sda_m = 1'b1; #q;
      scl_m = 1'b1; #q;
      sda_m = 1'b0; #q;
      scl_m = 1'b0; #q;
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; #q;
      scl_m = 1'b1; #q;
      sda_m = 1'b1; #(2*q);
   endtask

   task automatic i2c_bit(input logic b, output logic s);
      sda_m = b; #q;
      scl_m = 1'b1; #q;
      s = bus.sda_in; #q;
      scl_m = 1'b0; #q;
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
      i2c_bit(1'b1, ack);
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] b);
      logic s;
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
         i2c_bit(1'b1, s);
         b = {b[6:0], s};
      end
      i2c_bit(nack, s);
   endtask

   initial begin
      logic       ack, s;
      logic [7:0] b, d;
      logic [2:0] bits;
      int         rx0, tx0, oe0;

      repeat (4) @(posedge clk);
      #3;
      chk("rst_sda_oe", bus.sda_oe, 1'b0);
      chk("rst_rx_data", bus.rx_data, 8'h00);
      chk("rst_rx_valid", bus.rx_valid, 1'b0);
      chk("rst_tx_req", bus.tx_req, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_state", dut.state_q, k_t_idle);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #10;

      // write 0xA5 to own address
      rx0 = rx_cnt;
      i2c_start();
      chk("wr_busy_start", bus.busy, 1'b1);
      wr_byte(8'h84, ack);
      chk("wr_addr_ack", ack, 1'b0);
      wr_byte(8'hA5, ack);
      chk("wr_data_ack", ack, 1'b0);
      i2c_stop();
      chk("wr_rx_count", rx_cnt - rx0, 1);
      chk("wr_rx_data", rx_last, 8'hA5);
      chk("wr_busy_stop", bus.busy, 1'b0);

      // foreign address is ignored
      rx0 = rx_cnt; oe0 = oe_cnt;
      i2c_start();
      wr_byte(8'h86, ack);
      chk("mis_addr_ack", ack, 1'b1);
      wr_byte(8'hFF, ack);
      chk("mis_data_ack", ack, 1'b1);
      chk("mis_state", dut.state_q, k_t_ignore);
      i2c_stop();
      chk("mis_oe", oe_cnt - oe0, 0);
      chk("mis_rx_count", rx_cnt - rx0, 0);

      // general call is not acknowledged
      i2c_start();
      wr_byte(8'h00, ack);
      chk("gc_addr_ack", ack, 1'b1);
      i2c_stop();

      // read two bytes, ACK then NACK
      tx0 = tx_cnt;
      push_tx(8'h3C);
      push_tx(8'hC3);
      i2c_start();
      wr_byte(8'h85, ack);
      chk("rd_addr_ack", ack, 1'b0);
      rd_byte(1'b0, b);
      chk("rd_byte0", b, 8'h3C);
      rd_byte(1'b1, b);
      chk("rd_byte1", b, 8'hC3);
      i2c_stop();
      chk("rd_tx_count", tx_cnt - tx0, 2);
      chk("rd_busy_stop", bus.busy, 1'b0);

      // repeated START after half a write byte
      rx0 = rx_cnt; tx0 = tx_cnt;
      d = 8'($urandom);
      push_tx(d);
      i2c_start();
      wr_byte(8'h84, ack);
      chk("rs_addr0_ack", ack, 1'b0);
      for (int i = 7; i >= 4; i--) begin
         b = 8'hA5;
         i2c_bit(b[i], s);
      end
      i2c_rstart();
      wr_byte(8'h85, ack);
      chk("rs_addr1_ack", ack, 1'b0);
      rd_byte(1'b1, b);
      chk("rs_rd_byte", b, d);
      i2c_stop();
      chk("rs_rx_count", rx_cnt - rx0, 0);
      chk("rs_tx_count", tx_cnt - tx0, 1);

      // reset while acknowledging a write byte
      i2c_start();
      wr_byte(8'h84, ack);
      chk("ra_addr_ack", ack, 1'b0);
      for (int i = 7; i >= 0; i--) begin
         b = 8'h5A;
         i2c_bit(b[i], s);
      end
      sda_m = 1'b1;
      chk("ra_oe_before", bus.sda_oe, 1'b1);
      @(negedge clk);
      #3;
      reset = 1'b1;
      #2;
      chk("ra_oe_async", bus.sda_oe, 1'b0);
      chk("ra_state", dut.state_q, k_t_idle);
      chk("ra_busy", bus.busy, 1'b0);
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b0;
      i2c_stop();
      rx0 = rx_cnt;
      d = 8'($urandom);
      i2c_start();
      wr_byte(8'h84, ack);
      chk("ra_next_addr_ack", ack, 1'b0);
      wr_byte(d, ack);
      chk("ra_next_data_ack", ack, 1'b0);
      i2c_stop();
      chk("ra_next_rx_count", rx_cnt - rx0, 1);
      chk("ra_next_rx_data", rx_last, d);

      // STOP in the middle of a read byte (bit 4 of 0x10 leaves SDA free)
      oe0 = oe_cnt;
      push_tx(8'h10);
      i2c_start();
      wr_byte(8'h85, ack);
      chk("sm_addr_ack", ack, 1'b0);
      oe0 = oe_cnt;
      bits = 3'b111;
      for (int i = 0; i < 3; i++) begin
         i2c_bit(1'b1, s);
         bits = {bits[1:0], s};
      end
      chk("sm_bits", bits, 3'b000);
      chk("sm_oe_driven", oe_cnt > oe0, 1'b1);
      sda_m = 1'b0; #q;
      scl_m = 1'b1; #q;
      chk("sm_state_before", dut.state_q, k_t_rd_data);
      sda_m = 1'b1;
      repeat (sync_stages) @(posedge clk);
      #1;
      chk("sm_busy_held", bus.busy, 1'b1);
      @(posedge clk);
      #1;
      chk("sm_busy_cleared", bus.busy, 1'b0);
      chk("sm_oe", bus.sda_oe, 1'b0);
      chk("sm_state_idle", dut.state_q, k_t_idle);
      #(2*q);

      // random transactions against the reference rules
      for (int t = 0; t < 3; t++) begin
         logic [6:0] a;
         logic       rw, hit;
         int         nb;
         logic [7:0] exp_b [0:1];
         a   = ($urandom_range(0, 1) == 1) ? own_addr : 7'($urandom_range(0, 127));
         rw  = 1'($urandom_range(0, 1));
         nb  = $urandom_range(1, 2);
         hit = model_hit(a);
         rx0 = rx_cnt; tx0 = tx_cnt;
         for (int k = 0; k < 2; k++) begin
            exp_b[k] = 8'($urandom);
            if (hit && rw && k < nb) push_tx(exp_b[k]);
         end
         i2c_start();
         wr_byte({a, rw}, ack);
         chk("rnd_addr_ack", ack, !hit);
         for (int k = 0; k < nb; k++) begin
            if (!rw) begin
               wr_byte(exp_b[k], ack);
               chk("rnd_wr_ack", ack, !hit);
               if (hit) chk("rnd_wr_data", rx_last, exp_b[k]);
            end else begin
               rd_byte(k == nb - 1, b);
               chk("rnd_rd_data", b, hit ? exp_b[k] : 8'hFF);
            end
         end
         i2c_stop();
         chk("rnd_rx_count", rx_cnt - rx0, (hit && !rw) ? nb : 0);
         chk("rnd_tx_count", tx_cnt - tx0, (hit && rw) ? nb : 0);
         chk("rnd_busy", bus.busy, 1'b0);
      end

      chk("never_rx_and_tx", both_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
